// File: rtl/data_ram_sb_pkg.sv
// Shared defines and types for the data-memory responder and its store buffer.
// No logic of its own.
// No flow control.
`ifndef DATA_RAM_SB_DEFINES
`define DATA_RAM_SB_DEFINES
`define ZeroWord       32'h0000_0000
`define ChipEnable     1'b1
`define WriteEnable    1'b1
`define RegBus         31:0
`define DataMemNum     131072
`define DataMemNumLog2 17
`endif

package data_ram_sb_pkg;

    localparam int LANES = 4;

    typedef struct packed {
        logic [LANES-1:0] sel;
        logic [31:0]      dat;
    } sb_lane_t;

    // Overlay the selected byte lanes of dat onto base; sel[3] is bits 31:24.
    function automatic logic [31:0] lane_merge(input logic [31:0] base,
                                               input logic [31:0] dat,
                                               input logic [LANES-1:0] sel);
        logic [31:0] res;
        res = base;
        for (int i = 0; i < LANES; i++) begin
            if (sel[i]) res[8*i +: 8] = dat[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_ram_sb_store_buf.sv
// Circular store buffer exposing every entry and its valid bit for forwarding.
// Push/pop take effect at the rising edge; flags reflect registered state only.
// Push is dropped when full, pop is ignored when empty; the caller stalls upstream.
module store_buf
    import data_ram_sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [AW-1:0]              push_addr,
    input  sb_lane_t                   push_lane,
    input  logic                       pop,
    output logic [$clog2(DEPTH)-1:0]   head_ptr,
    output logic [AW-1:0]              ent_addr [DEPTH],
    output sb_lane_t                   ent_lane [DEPTH],
    output logic [DEPTH-1:0]           ent_vld,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_ptr = head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload is qualified by ent_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            ent_addr[tail] <= push_addr;
            ent_lane[tail] <= push_lane;
        end
    end

    always_comb begin
        logic [PW-1:0] off;
        off     = '0;
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PW'(i) - head;
            ent_vld[i] = ({1'b0, off} < count);
        end
    end

endmodule

// File: rtl/data_ram_sb.sv
// RAM end of the MEM-stage load/store port: word array fronted by a store buffer.
// Loads answer combinationally with buffered bytes forwarded; stores post at the edge.
// Stall requested only when a store meets a full buffer; loads never stall.
module data_ram_sb
    import data_ram_sb_pkg::*;
#(
    parameter int ADDR_W   = `DataMemNumLog2,
    parameter int SB_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mem_ce_i,
    input  logic           mem_we_i,
    input  logic [31:0]    mem_addr_i,
    input  logic [3:0]     mem_sel_i,
    input  logic [`RegBus] mem_data_i,
    output logic [`RegBus] mem_data_o,
    output logic           stall_req_o,
    output logic           sb_empty_o
);
    localparam int PW = $clog2(SB_DEPTH);

    logic [31:0]       mem_arr [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] word_addr;
    logic              is_load;
    logic              store_req;
    logic              sb_full;
    logic              sb_empty;
    logic              sb_push;
    logic              sb_pop;
    logic [PW-1:0]     head_ptr;
    logic [ADDR_W-1:0] ent_addr [SB_DEPTH];
    sb_lane_t          ent_lane [SB_DEPTH];
    logic [SB_DEPTH-1:0] ent_vld;
    logic [31:0]       fwd_dat;
    logic              unused_addr_bits;

    assign word_addr        = mem_addr_i[ADDR_W+1:2];
    assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    assign is_load   = (mem_ce_i == `ChipEnable) && (mem_we_i != `WriteEnable);
    assign store_req = (mem_ce_i == `ChipEnable) && (mem_we_i == `WriteEnable) && (mem_sel_i != 4'b0000);

    // A load owns the single array port; any other cycle may retire the head entry.
    assign sb_push     = store_req && !sb_full;
    assign sb_pop      = !is_load && !sb_empty;
    assign stall_req_o = store_req && sb_full;
    assign sb_empty_o  = sb_empty;

    store_buf #(
        .DEPTH (SB_DEPTH),
        .AW    (ADDR_W)
    ) u_store_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (sb_push),
        .push_addr (word_addr),
        .push_lane ('{sel: mem_sel_i, dat: mem_data_i}),
        .pop       (sb_pop),
        .head_ptr  (head_ptr),
        .ent_addr  (ent_addr),
        .ent_lane  (ent_lane),
        .ent_vld   (ent_vld),
        .full      (sb_full),
        .empty     (sb_empty)
    );

    // Walk oldest to youngest so the most recent store to a byte wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        fwd_dat = mem_arr[word_addr];
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx = head_ptr + PW'(k);
            if (ent_vld[idx] && (ent_addr[idx] == word_addr)) begin
                fwd_dat = lane_merge(fwd_dat, ent_lane[idx].dat, ent_lane[idx].sel);
            end
        end
    end

    assign mem_data_o = (rst && is_load) ? fwd_dat : `ZeroWord;

    always_ff @(posedge clk) begin
        if (sb_pop) begin
            for (int i = 0; i < LANES; i++) begin
                if (ent_lane[head_ptr].sel[i]) begin
                    mem_arr[ent_addr[head_ptr]][8*i +: 8] <= ent_lane[head_ptr].dat[8*i +: 8];
                end
            end
        end
    end

endmodule
